// File: rtl/apb_pkg.sv
// ============================================================================
//  Package : apb_pkg
//  Shared state encoding, data width and response record for the APB initiator.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package apb_pkg;

    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic [APB_DATA_WIDTH-1:0] rdata;
        logic                      err;
        logic                      timeout;
    } apb_rsp_t;

endpackage

`default_nettype wire

// File: rtl/apb_request_master.sv
// ============================================================================
//  Module  : apb_request_master
//  Valid/ready request channel to APB SETUP/ACCESS transfers, one outstanding.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module apb_request_master
    import apb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
    input  logic                      req_write_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    apb_state_t                state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    apb_rsp_t                  rsp_q, rsp_d;
    logic                      rsp_valid_q, rsp_valid_d;

    logic [CNT_W-1:0]          cnt_inc;
    logic                      timeout_hit;
    logic                      accept;

    // Ready is forced low during reset so every output reads 0 while HRESET is held.
    assign req_ready_o = !HRESET && (state_q == IDLE) && (!rsp_valid_q || rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIMIT);

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        cnt_d       = cnt_q;
        rsp_d       = rsp_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready_i;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    paddr_d  = req_addr_i;
                    pwdata_d = req_wdata_i;
                    pwrite_d = req_write_i;
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A ready slave wins over a timeout landing in the same cycle.
                if (PREADY) begin
                    rsp_d.rdata   = pwrite_q ? '0 : PRDATA;
                    rsp_d.err     = PSLVERR;
                    rsp_d.timeout = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = IDLE;
                end else if (timeout_hit) begin
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    rsp_valid_d   = 1'b1;
                    state_d       = IDLE;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            cnt_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            cnt_q       <= cnt_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign PADDR         = paddr_q;
    assign PWDATA        = pwdata_q;
    assign PWRITE        = pwrite_q;
    assign PSEL          = (state_q != IDLE);
    assign PENABLE       = (state_q == ACCESS);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_q.rdata;
    assign rsp_err_o     = rsp_q.err;
    assign rsp_timeout_o = rsp_q.timeout;

endmodule

`default_nettype wire

// File: tb/tb_apb_request_master.sv
// ============================================================================
//  Module  : tb_apb_request_master
//  Self-checking bench: directed scenarios plus randomized transfers vs. a model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_apb_request_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // DUT with a short timeout
    logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready;
    logic [11:0] req_addr, paddr;
    logic [31:0] req_wdata, rsp_rdata, pwdata, prdata;
    logic        rsp_err, rsp_timeout, pwrite, psel, penable, pready, pslverr;

    // DUT with the timeout disabled
    logic        z_req_valid, z_req_ready, z_req_write, z_rsp_valid, z_rsp_ready;
    logic [11:0] z_req_addr, z_paddr;
    logic [31:0] z_req_wdata, z_rsp_rdata, z_pwdata, z_prdata;
    logic        z_rsp_err, z_rsp_timeout, z_pwrite, z_psel, z_penable, z_pready, z_pslverr;

    int n_tests = 0;
    int n_fail  = 0;

    apb_request_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(TO)) dut (
        .HCLK(clk), .HRESET(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_write_i(req_write),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
        .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    apb_request_master #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(0)) dut_z (
        .HCLK(clk), .HRESET(rst),
        .req_valid_i(z_req_valid), .req_ready_o(z_req_ready), .req_addr_i(z_req_addr),
        .req_wdata_i(z_req_wdata), .req_write_i(z_req_write),
        .rsp_valid_o(z_rsp_valid), .rsp_ready_i(z_rsp_ready), .rsp_rdata_o(z_rsp_rdata),
        .rsp_err_o(z_rsp_err), .rsp_timeout_o(z_rsp_timeout),
        .PADDR(z_paddr), .PWDATA(z_pwdata), .PWRITE(z_pwrite), .PSEL(z_psel), .PENABLE(z_penable),
        .PRDATA(z_prdata), .PREADY(z_pready), .PSLVERR(z_pslverr)
    );

    // Issue a request at the current negedge; returns at the negedge of the SETUP cycle.
    task automatic issue(input logic [11:0] a, input logic [31:0] d, input logic w);
        req_valid = 1'b1; req_addr = a; req_wdata = d; req_write = w;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0; req_addr = 12'($urandom); req_wdata = $urandom; req_write = 1'($urandom);
        #1;
        n_tests++;
        if ({psel, penable} !== 2'b10) begin
            n_fail++; $display("FAIL setup_phase: psel/penable got %b want 10", {psel, penable});
        end
    endtask

    // Plays the slave through ACCESS and checks the response against the model.
    task automatic complete(input logic [11:0] a, input logic [31:0] d, input logic w,
                            input int waits, input logic err, input logic [31:0] rd,
                            input int hold, input bit consume);
        int          nacc;
        bit          bad;
        bit          timed;
        int          exp_acc;
        logic [31:0] exp_rdata;
        logic        exp_err;
        timed     = (waits >= TO);
        exp_acc   = timed ? TO : waits + 1;
        exp_rdata = (timed || w) ? 32'h0 : rd;
        exp_err   = timed || err;
        nacc = 0;
        bad  = 0;
        @(negedge clk);
        while (penable === 1'b1 && nacc < 2000) begin
            nacc++;
            if (psel !== 1'b1 || paddr !== a || pwrite !== w || (w && pwdata !== d)) bad = 1;
            pready  = (nacc > waits);
            pslverr = pready ? err : 1'($urandom);
            prdata  = pready ? rd : $urandom;
            @(negedge clk);
        end
        pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
        #1;
        n_tests++;
        if (nacc !== exp_acc || bad) begin
            n_fail++; $display("FAIL access_cycles: got %0d (bus_unstable=%0d) want %0d", nacc, bad, exp_acc);
        end
        n_tests++;
        if ({psel, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b0, 1'b1, exp_rdata, exp_err, timed}) begin
            n_fail++;
            $display("FAIL response: got psel=%b v=%b rd=%h err=%b to=%b want psel=0 v=1 rd=%h err=%b to=%b",
                     psel, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, exp_rdata, exp_err, timed);
        end
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            if ({rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, exp_rdata, exp_err, timed}) bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++; $display("FAIL response_hold: got rd=%h want rd=%h", rsp_rdata, exp_rdata);
        end
        if (consume) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            #1;
            n_tests++;
            if (rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL response_consumed: rsp_valid got %b want 0", rsp_valid);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, paddr, pwdata, pwrite, psel, penable} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b v=%b psel=%b pen=%b paddr=%h want all 0",
                     req_ready, rsp_valid, psel, penable, paddr);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        issue(12'h000, 32'hFFFF_0000, 1'b1);
        complete(12'h000, 32'hFFFF_0000, 1'b1, 0, 1'b0, 32'hDEAD_BEEF, 0, 1);
    endtask

    task automatic test_read_waits();
        issue(12'h004, 32'h0, 1'b0);
        complete(12'h004, 32'h0, 1'b0, 3, 1'b0, 32'hA5A5_0001, 0, 1);
    endtask

    task automatic test_slverr();
        issue(12'h008, 32'h1234_5678, 1'b1);
        complete(12'h008, 32'h1234_5678, 1'b1, 0, 1'b1, 32'h0, 0, 1);
    endtask

    task automatic test_timeout();
        issue(12'h00C, 32'h0, 1'b0);
        complete(12'h00C, 32'h0, 1'b0, 50, 1'b0, 32'h5555_AAAA, 1, 1);
    endtask

    task automatic test_no_timeout();
        int bad;
        bad = 0;
        z_req_valid = 1'b1; z_req_addr = 12'h3F3; z_req_wdata = 32'h0; z_req_write = 1'b0;
        @(negedge clk);
        z_req_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if (z_psel !== 1'b1 || z_penable !== 1'b1 || z_rsp_valid !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL no_timeout_wait: %0d bad cycles, want 0", bad);
        end
        z_pready = 1'b1; z_prdata = 32'h1234_5678;
        @(negedge clk);
        z_pready = 1'b0;
        #1;
        n_tests++;
        if ({z_psel, z_rsp_valid, z_rsp_rdata, z_rsp_err, z_rsp_timeout} !== {1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL no_timeout_rsp: got v=%b rd=%h err=%b to=%b want v=1 rd=12345678 err=0 to=0",
                     z_rsp_valid, z_rsp_rdata, z_rsp_err, z_rsp_timeout);
        end
        z_rsp_ready = 1'b1;
        @(negedge clk);
        z_rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bad;
        issue(12'h010, 32'h0, 1'b0);
        complete(12'h010, 32'h0, 1'b0, 1, 1'b0, 32'hCAFE_0010, 0, 0);
        req_valid = 1'b1; req_addr = 12'h014; req_wdata = 32'hBEEF_0014; req_write = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (req_ready !== 1'b0 || psel !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_0010) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL backpressure: %0d bad cycles, want 0", bad);
        end
        rsp_ready = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL same_cycle_accept: req_ready got %b want 1", req_ready);
        end
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b0;
        #1;
        n_tests++;
        if ({psel, penable, rsp_valid} !== 3'b100) begin
            n_fail++; $display("FAIL b2b_setup: psel/pen/v got %b want 100", {psel, penable, rsp_valid});
        end
        complete(12'h014, 32'hBEEF_0014, 1'b1, 0, 1'b0, 32'h0, 0, 1);
    endtask

    task automatic test_reset_mid_access();
        int bad;
        issue(12'h020, 32'h0, 1'b0);
        pready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({psel, penable, rsp_valid, paddr} !== '0) begin
            n_fail++; $display("FAIL reset_mid_access: psel/pen/v got %b paddr=%h want 000/000", {psel, penable, rsp_valid}, paddr);
        end
        @(negedge clk);
        rst = 1'b0; pready = 1'b1; prdata = 32'h7777_7777;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (rsp_valid !== 1'b0 || psel !== 1'b0) bad++;
        end
        pready = 1'b0;
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL no_rsp_after_reset: %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_random();
        logic [11:0] a;
        logic [31:0] d, rd;
        logic        w, e;
        int          waits;
        for (int n = 0; n < 20; n++) begin
            a     = 12'($urandom);
            d     = $urandom;
            rd    = $urandom;
            w     = 1'($urandom);
            e     = 1'($urandom_range(0, 3) == 0);
            waits = $urandom_range(0, 6);
            issue(a, d, w);
            complete(a, d, w, waits, e, rd, $urandom_range(0, 2), 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_addr = 0; req_wdata = 0; req_write = 0; rsp_ready = 0;
        prdata = 0; pready = 0; pslverr = 0;
        z_req_valid = 0; z_req_addr = 0; z_req_wdata = 0; z_req_write = 0; z_rsp_ready = 0;
        z_prdata = 0; z_pready = 0; z_pslverr = 0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        test_write_zero_wait();
        test_read_waits();
        test_slverr();
        test_timeout();
        test_no_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
